issue_select: RTL

ISSUE_SELECT -- requirements
Module: issue_select

---
 rtl/issue_select_if.sv | 28 ++
 rtl/issue_select.sv | 112 +++++++++++
 2 files changed

// File: rtl/issue_select_if.sv
// Issue-select bundle: allocation, readiness and FU-busy inputs plus grant/occupancy outputs.
// master = issue-queue side driving the selector, slave = the issue_select block.
interface issue_select_if #(
  parameter int ISSUE_NUM = 4,
  parameter int CIQ_DEPTH = 16,
  parameter int IDX_W     = 4,
  parameter int PORT_W    = 2
);
  logic                       flush;
  logic                       alloc_en;
  logic [IDX_W-1:0]           alloc_idx;
  logic [PORT_W-1:0]          alloc_port;
  logic [CIQ_DEPTH-1:0]       entry_rdy;
  logic [ISSUE_NUM-1:0]       fu_busy;
  logic [ISSUE_NUM-1:0]       arbit_grant;
  logic [ISSUE_NUM*IDX_W-1:0] grant_idx;
  logic [CIQ_DEPTH-1:0]       entry_valid;

  modport master (
    output flush, alloc_en, alloc_idx, alloc_port, entry_rdy, fu_busy,
    input  arbit_grant, grant_idx, entry_valid
  );

  modport slave (
    input  flush, alloc_en, alloc_idx, alloc_port, entry_rdy, fu_busy,
    output arbit_grant, grant_idx, entry_valid
  );
endinterface

// File: rtl/issue_select.sv
// Per-port issue selector over a CIQ_DEPTH-entry queue with one-cycle registered grants.
// Define ISSUE_AGE_ORDER_EN for oldest-first (age matrix); otherwise lowest-index-first.
module issue_select #(
  parameter int ISSUE_NUM = 4,
  parameter int CIQ_DEPTH = 16,
  parameter int IDX_W     = 4,
  parameter int PORT_W    = 2
) (
  input logic          clk,
  input logic          rst,
  issue_select_if.slave bus
);
  logic [CIQ_DEPTH-1:0]       valid_q;
  logic [PORT_W-1:0]          port_q [CIQ_DEPTH];
`ifdef ISSUE_AGE_ORDER_EN
  // older_q[i][j] = 1 when entry i was allocated before entry j
  logic [CIQ_DEPTH-1:0]       older_q [CIQ_DEPTH];
  logic                       blocked;
`endif
  logic [CIQ_DEPTH-1:0]       elig_p0 [ISSUE_NUM];
  logic [ISSUE_NUM-1:0]       sel_vld_p0;
  logic [IDX_W-1:0]           sel_idx_p0 [ISSUE_NUM];
  logic [CIQ_DEPTH-1:0]       issued_p0;
  logic                       alloc_ok;
  logic [ISSUE_NUM-1:0]       grant_vld_p1;
  logic [ISSUE_NUM*IDX_W-1:0] grant_idx_p1;

  // ---- stage p0: eligibility and per-port selection from current state ----
  always_comb begin
    for (int p = 0; p < ISSUE_NUM; p++) begin
      for (int i = 0; i < CIQ_DEPTH; i++) begin
        elig_p0[p][i] = valid_q[i] & bus.entry_rdy[i] &
                        (port_q[i] == PORT_W'(p)) & ~bus.fu_busy[p];
      end
    end
  end

  always_comb begin
    issued_p0 = '0;
`ifdef ISSUE_AGE_ORDER_EN
    blocked = 1'b0;
`endif
    for (int p = 0; p < ISSUE_NUM; p++) begin
      sel_vld_p0[p] = 1'b0;
      sel_idx_p0[p] = '0;
`ifdef ISSUE_AGE_ORDER_EN
      for (int i = 0; i < CIQ_DEPTH; i++) begin
        blocked = 1'b0;
        for (int j = 0; j < CIQ_DEPTH; j++) begin
          if (elig_p0[p][j] && older_q[j][i]) blocked = 1'b1;
        end
        if (elig_p0[p][i] && !blocked) begin
          sel_vld_p0[p] = 1'b1;
          sel_idx_p0[p] = IDX_W'(i);
        end
      end
`else
      // Scan downwards so the lowest eligible index is the last one written
      for (int i = CIQ_DEPTH - 1; i >= 0; i--) begin
        if (elig_p0[p][i]) begin
          sel_vld_p0[p] = 1'b1;
          sel_idx_p0[p] = IDX_W'(i);
        end
      end
`endif
      if (sel_vld_p0[p]) issued_p0[sel_idx_p0[p]] = 1'b1;
    end
  end

  assign alloc_ok = bus.alloc_en & ~valid_q[bus.alloc_idx];

  // ---- stage p1: registered grants, occupancy and age update ----
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q      <= '0;
      grant_vld_p1 <= '0;
      grant_idx_p1 <= '0;
      for (int i = 0; i < CIQ_DEPTH; i++) begin
        port_q[i] <= '0;
`ifdef ISSUE_AGE_ORDER_EN
        older_q[i] <= '0;
`endif
      end
    end else if (bus.flush) begin
      valid_q      <= '0;
      grant_vld_p1 <= '0;
`ifdef ISSUE_AGE_ORDER_EN
      for (int i = 0; i < CIQ_DEPTH; i++) older_q[i] <= '0;
`endif
    end else begin
      valid_q      <= (valid_q & ~issued_p0) |
                      (alloc_ok ? (CIQ_DEPTH'(1) << bus.alloc_idx) : '0);
      grant_vld_p1 <= sel_vld_p0;
      for (int p = 0; p < ISSUE_NUM; p++) begin
        if (sel_vld_p0[p]) grant_idx_p1[p*IDX_W +: IDX_W] <= sel_idx_p0[p];
      end
      if (alloc_ok) begin
        port_q[bus.alloc_idx] <= bus.alloc_port;
`ifdef ISSUE_AGE_ORDER_EN
        older_q[bus.alloc_idx] <= '0;
        for (int k = 0; k < CIQ_DEPTH; k++) begin
          if (valid_q[k]) older_q[k][bus.alloc_idx] <= 1'b1;
        end
`endif
      end
    end
  end

  assign bus.arbit_grant = grant_vld_p1;
  assign bus.grant_idx   = grant_idx_p1;
  assign bus.entry_valid = valid_q;
endmodule
